// File: rtl/force_release_pkg.sv
// Shared types, gate-mode constants and the reduction helper for the
// force/release override controller.
package force_release_pkg;

  // Per-channel override state.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    FORCED = 2'd1,
    ORPHAN = 2'd2
  } chan_state_e;

  // Gate functions selectable through the MODE parameter.
  localparam int MODE_AND = 0;
  localparam int MODE_OR  = 1;
  localparam int MODE_XOR = 2;

  // Widest gate the reduction helper accepts; unused upper bits are ignored.
  localparam int MAX_NIN = 32;

  // Reduce the low 'nin' bits of 'bits' with the selected gate function.
  function automatic logic gate_reduce(input logic [MAX_NIN-1:0] bits,
                                       input int nin,
                                       input int mode);
    logic acc;
    acc = (mode == MODE_AND) ? 1'b1 : 1'b0;
    for (int i = 0; i < MAX_NIN; i++) begin
      if (i < nin) begin
        case (mode)
          MODE_AND: acc = acc & bits[i];
          MODE_OR:  acc = acc | bits[i];
          MODE_XOR: acc = acc ^ bits[i];
          default:  acc = 1'b0;
        endcase
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/force_release_chan.sv
// One override channel: FSM, force timer, held value, registered output,
// sticky orphan / spurious-release flags and a same-cycle fault-event pulse.
module force_release_chan
  import force_release_pkg::*;
#(
  parameter int NIN     = 3,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIN-1:0] data,
  input  logic           force_req,
  input  logic           force_val,
  input  logic           release_req,
  input  logic           orphan_clr,
  output logic           dout,
  output logic           forced,
  output logic           orphan,
  output logic           spur_rel,
  output logic           fault_evt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  chan_state_e          state_r;
  logic                 hold_r;
  logic [TW-1:0]        timer_r;
  logic [MAX_NIN-1:0]   pad_s;
  logic                 gate_s;
  logic                 orph_evt_s;
  logic                 spur_evt_s;

  // Zero-extend the channel inputs and reduce them with the configured gate.
  always_comb begin
    pad_s          = '0;
    pad_s[NIN-1:0] = data;
    gate_s         = gate_reduce(pad_s, NIN, MODE);
  end

  // Detect the two fault events: orphan entry and release while FREE.
  always_comb begin
    orph_evt_s = 1'b0;
    spur_evt_s = 1'b0;
    case (state_r)
      FREE: begin
        if (release_req && !force_req) begin
          spur_evt_s = 1'b1;
        end else begin
          spur_evt_s = 1'b0;
        end
      end
      FORCED: begin
        if (!force_req && !release_req && (timer_r == TMAX)) begin
          orph_evt_s = 1'b1;
        end else begin
          orph_evt_s = 1'b0;
        end
      end
      default: begin
        orph_evt_s = 1'b0;
        spur_evt_s = 1'b0;
      end
    endcase
    fault_evt = orph_evt_s | spur_evt_s;
  end

  // Channel FSM with timer, held value and next-state-based registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FREE;
      hold_r  <= 1'b0;
      timer_r <= '0;
      dout    <= 1'b0;
      forced  <= 1'b0;
    end else begin
      case (state_r)
        FREE: begin
          if (force_req) begin
            // Force wins over a coincident release: no spurious flag here.
            state_r <= FORCED;
            hold_r  <= force_val;
            timer_r <= '0;
            dout    <= force_val;
            forced  <= 1'b1;
          end else begin
            dout    <= gate_s;
            forced  <= 1'b0;
          end
        end
        FORCED: begin
          if (release_req) begin
            // Release wins over a coincident force.
            state_r <= FREE;
            timer_r <= '0;
            dout    <= gate_s;
            forced  <= 1'b0;
          end else if (force_req) begin
            hold_r  <= force_val;
            timer_r <= '0;
            dout    <= force_val;
            forced  <= 1'b1;
          end else if (timer_r == TMAX) begin
            state_r <= ORPHAN;
            dout    <= hold_r;
            forced  <= 1'b1;
          end else begin
            timer_r <= timer_r + TONE;
            dout    <= hold_r;
            forced  <= 1'b1;
          end
        end
        ORPHAN: begin
          if (release_req) begin
            state_r <= FREE;
            timer_r <= '0;
            dout    <= gate_s;
            forced  <= 1'b0;
          end else if (force_req) begin
            state_r <= FORCED;
            hold_r  <= force_val;
            timer_r <= '0;
            dout    <= force_val;
            forced  <= 1'b1;
          end else begin
            dout    <= hold_r;
            forced  <= 1'b1;
          end
        end
        default: begin
          state_r <= FREE;
          timer_r <= '0;
          dout    <= gate_s;
          forced  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle beats orphan_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orphan   <= 1'b0;
      spur_rel <= 1'b0;
    end else begin
      if (orph_evt_s) begin
        orphan <= 1'b1;
      end else if (orphan_clr) begin
        orphan <= 1'b0;
      end else begin
        orphan <= orphan;
      end
      if (spur_evt_s) begin
        spur_rel <= 1'b1;
      end else if (orphan_clr) begin
        spur_rel <= 1'b0;
      end else begin
        spur_rel <= spur_rel;
      end
    end
  end

endmodule

// File: rtl/force_release_ctrl.sv
// Multi-channel force/release override controller: CH channel instances
// plus a saturating counter of fault events across all channels.
module force_release_ctrl
  import force_release_pkg::*;
#(
  parameter int CH      = 4,
  parameter int NIN     = 3,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*NIN-1:0] data_in,
  input  logic [CH-1:0]     force_req,
  input  logic [CH-1:0]     force_val,
  input  logic [CH-1:0]     release_req,
  input  logic [CH-1:0]     orphan_clr,
  output logic [CH-1:0]     dout,
  output logic [CH-1:0]     forced,
  output logic [CH-1:0]     orphan,
  output logic [CH-1:0]     spur_rel,
  output logic [CNTW-1:0]   fault_cnt
);

  // Adder wide enough for the counter plus every channel faulting at once.
  localparam int SW = $clog2(CH + 1);
  localparam int AW = CNTW + SW;
  localparam logic [AW-1:0] CNT_MAX = AW'((2 ** CNTW) - 1);

  logic [CH-1:0]   fault_evt_s;
  logic [AW-1:0]   evt_sum_s;
  logic [AW-1:0]   cnt_sum_s;
  logic [CNTW-1:0] cnt_next_s;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    force_release_chan #(
      .NIN     (NIN),
      .MODE    (MODE),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .data        (data_in[c*NIN +: NIN]),
      .force_req   (force_req[c]),
      .force_val   (force_val[c]),
      .release_req (release_req[c]),
      .orphan_clr  (orphan_clr[c]),
      .dout        (dout[c]),
      .forced      (forced[c]),
      .orphan      (orphan[c]),
      .spur_rel    (spur_rel[c]),
      .fault_evt   (fault_evt_s[c])
    );
  end

  // Sum this cycle's fault events and saturate the running count.
  always_comb begin
    evt_sum_s = '0;
    for (int i = 0; i < CH; i++) begin
      evt_sum_s = evt_sum_s + AW'(fault_evt_s[i]);
    end
    cnt_sum_s = AW'(fault_cnt) + evt_sum_s;
    if (cnt_sum_s > CNT_MAX) begin
      cnt_next_s = CNT_MAX[CNTW-1:0];
    end else begin
      cnt_next_s = cnt_sum_s[CNTW-1:0];
    end
  end

  // Fault counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt <= '0;
    end else begin
      fault_cnt <= cnt_next_s;
    end
  end

endmodule
